demux_w_reg: RTL and testbench
==============================

# demux_w_reg

Registered 1-to-4 demultiplexer: the distribution counterpart of the team's registered 4-to-1 mux. It accepts one word per handshake and steers it into one of four holding registers, R0..R3. The destination comes either from an explicit select or from an internal round-robin pointer. Each holding register carries a valid flag that its consumer clears with an acknowledge, so a word is never overwritten before it has been taken.

## Interface
Parameters:
- W, default 1: data width of the input word and of each holding register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  W  word to distribute.
- in_sel  input  2  explicit destination (0..3); used only when rr_mode=0.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can take the word this cycle; combinational.
- rr_mode  input  1  1 = destination is the internal pointer; 0 = destination is in_sel.
- R0, R1, R2, R3  output  W each  holding registers.
- out_valid  output  4  bit N set means RN holds an untaken word.
- out_ack  input  4  bit N asserted means the consumer takes RN this cycle.
- rr_ptr  output  2  current round-robin pointer.

## Operation
- Destination: dest = rr_ptr when rr_mode=1; dest = in_sel when rr_mode=0. All four codes are legal, so there is no default path.
- in_ready = !out_valid[dest] || out_ack[dest]. This allows a same-cycle take and refill.
- Accept means in_valid && in_ready. On accept:
  - R[dest] <= in_data.
  - out_valid[dest] <= 1.
  - If rr_mode=1, rr_ptr <= rr_ptr+1, wrapping 3 -> 0.
- Take: out_ack[N] && out_valid[N] clears out_valid[N], unless the same cycle is also an accept to N. In that case out_valid[N] stays 1 and RN holds the new word.
- out_ack[N] while out_valid[N]=0 is ignored, with no state change.
- Acks on several channels in one cycle are independent; all are honoured.
- in_valid=1 with in_ready=0 is a stall:
  - no register changes;
  - the producer holds in_data, in_sel and rr_mode stable until accept.
- rr_ptr advances only on an accept while rr_mode=1. Toggling rr_mode does not change the pointer, and switching back resumes from the held value.
- Holding registers change only on an accept to that channel. Data stays visible after a take; only out_valid drops.
- Reset has priority over every other event in the same cycle, including an accept or take mid-operation. After reset:
  - R0..R3 = 0;
  - out_valid = 4'b0000;
  - rr_ptr = 0.
  - in_ready then evaluates to 1.

## Timing
- Latency: a word accepted at edge k is visible on R[dest], with out_valid[dest]=1, immediately after edge k.
- A take at edge k gives out_valid[N]=0 after edge k.
- Throughput is one accept per cycle when the destination is empty or being acked in that cycle.
- in_ready is combinational from out_valid, out_ack, rr_mode, in_sel and rr_ptr. It has no path from in_valid.
- Back-pressure on one channel does not stall the others in explicit mode. In rr_mode, a full channel at rr_ptr stalls all traffic until it is acked (strict order, no skipping).
- Reset is sampled only at the clock edge; deasserting rst mid-cycle has no effect until the next edge.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> R0..R3=0, out_valid=0000, rr_ptr=0, and nothing is captured; in_ready=1 after release.
- Explicit steering (W=8):
  - rr_mode=0; send 0xA0/sel0, 0xA1/sel1, 0xA2/sel2, 0xA3/sel3 on consecutive cycles -> R0..R3 = A0..A3 and out_valid=1111.
  - A fifth word to sel2 -> in_ready=0 and no change.
- Take and refill: with R2 full, assert out_ack[2] and send 0x55/sel2 in the same cycle -> accept, R2=0x55, out_valid[2] stays 1.
- Round robin: rr_mode=1, channels empty, send six words 0x10..0x15 with acks held high -> destinations 0,1,2,3,0,1 and rr_ptr ends at 2 (wrap checked).
- Round-robin stall: rr_mode=1, rr_ptr=1, R1 full and no ack -> in_ready=0 even though R0, R2 and R3 are empty; ack R1 -> the next word lands in R1.
- Spurious ack and reset mid-stream:
  - out_ack=1111 with out_valid=0000 -> no change.
  - Assert rst in the same cycle as an accept to ch3 -> R3=0, out_valid[3]=0, rr_ptr=0.

Source files
------------

// File: rtl/demux_w_reg.sv
// demux_w_reg: registered 1-to-4 demultiplexer with per-channel valid/ack holding registers.
//   Destination is in_sel (rr_mode=0) or an internal round-robin pointer (rr_mode=1).
//   Latency: an accepted word is visible on R[dest] with out_valid[dest]=1 right after the accepting edge.
//   Backpressure: in_ready drops while the destination holds an untaken word that is not acked this cycle.
//   In rr_mode a full channel at rr_ptr stalls all traffic (strict order, no skipping).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_sel/in_valid  producer word, explicit destination, word present
//   in_ready                 combinational accept indication (no path from in_valid)
//   rr_mode                  1 = steer by rr_ptr, 0 = steer by in_sel
//   R0..R3, out_valid        holding registers and their untaken-word flags
//   out_ack                  per-channel take strobes from the consumers
//   rr_ptr                   current round-robin pointer
module demux_w_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rr_mode,
  output logic [W-1:0] R0,
  output logic [W-1:0] R1,
  output logic [W-1:0] R2,
  output logic [W-1:0] R3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ack,
  output logic [1:0]   rr_ptr
);

  logic [W-1:0] hold [4];
  logic [1:0]   dest;
  logic         accept;

  assign dest     = rr_mode ? rr_ptr : in_sel;
  // A full destination can still take a word when its consumer acks in the same cycle.
  assign in_ready = !out_valid[dest] || out_ack[dest];
  assign accept   = in_valid && in_ready;

  assign R0 = hold[0];
  assign R1 = hold[1];
  assign R2 = hold[2];
  assign R3 = hold[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hold[i] <= '0;
      end
      out_valid <= 4'b0000;
      rr_ptr    <= 2'd0;
    end else begin
      // Takes first; an accept to the same channel below overrides the clear.
      for (int i = 0; i < 4; i++) begin
        if (out_ack[i] && out_valid[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
      if (accept) begin
        hold[dest]      <= in_data;
        out_valid[dest] <= 1'b1;
        if (rr_mode) begin
          rr_ptr <= rr_ptr + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_w_reg.sv
module tb_demux_w_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_sel = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       rr_mode = 1'b0;
  logic [7:0] R0, R1, R2, R3;
  logic [3:0] out_valid;
  logic [3:0] out_ack = 4'b0000;
  logic [1:0] rr_ptr;

  demux_w_reg #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .rr_mode(rr_mode),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .out_valid(out_valid), .out_ack(out_ack), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] dest;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rsel(input logic [1:0] i);
    case (i)
      2'd0: rsel = R0;
      2'd1: rsel = R1;
      2'd2: rsel = R2;
      default: rsel = R3;
    endcase
  endfunction

  // Called at posedge+1; issues one word expected to be accepted this cycle.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [1:0] exp_dest);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    q.push_back('{dest: exp_dest, data: d});
    #1 chk("send_ready", in_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Monitor: on every observed accept, pop the expected word and check where it landed.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) begin
        @(posedge clk); #2;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got sel=%0d data=%0h expected no accept", in_sel, in_data);
        end else begin
          mon_e = q.pop_front();
          chk("mon_data", rsel(mon_e.dest), mon_e.data);
          chk("mon_valid", out_valid[mon_e.dest], 1'b1);
        end
      end
    end
  end

  initial begin
    // Reset held two cycles with a word presented: nothing may be captured.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_R0", R0, 8'h00);
    chk("rst_R1", R1, 8'h00);
    chk("rst_R2", R2, 8'h00);
    chk("rst_R3", R3, 8'h00);
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_ptr", rr_ptr, 2'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1 chk("rst_ready", in_ready, 1'b1);
    idle_cycle();

    // Explicit steering on consecutive cycles.
    send(8'hA0, 2'd0, 2'd0);
    send(8'hA1, 2'd1, 2'd1);
    send(8'hA2, 2'd2, 2'd2);
    send(8'hA3, 2'd3, 2'd3);
    chk("expl_valid", out_valid, 4'b1111);

    // Fifth word to full ch2 stalls.
    in_data = 8'h77; in_sel = 2'd2; in_valid = 1'b1;
    #1 chk("full_stall_ready", in_ready, 1'b0);
    idle_cycle();
    chk("full_stall_R2", R2, 8'hA2);
    chk("full_stall_valid", out_valid, 4'b1111);

    // Take and refill ch2 in the same cycle.
    out_ack = 4'b0100;
    send(8'h55, 2'd2, 2'd2);
    out_ack = 4'b0000; in_valid = 1'b0;
    chk("refill_valid", out_valid, 4'b1111);

    // Drain all channels.
    out_ack = 4'b1111;
    idle_cycle();
    chk("drain_valid", out_valid, 4'b0000);
    chk("drain_keeps_R2", R2, 8'h55);

    // Round robin with acks held high: 0,1,2,3,0,1.
    rr_mode = 1'b1;
    send(8'h10, 2'd3, 2'd0);
    send(8'h11, 2'd3, 2'd1);
    send(8'h12, 2'd3, 2'd2);
    send(8'h13, 2'd3, 2'd3);
    send(8'h14, 2'd3, 2'd0);
    send(8'h15, 2'd3, 2'd1);
    chk("rr_ptr_wrap", rr_ptr, 2'd2);
    chk("rr_valid", out_valid, 4'b0010);

    // Leave R1 full, advance pointer around to 1.
    out_ack = 4'b1101;
    send(8'h16, 2'd0, 2'd2);
    send(8'h17, 2'd0, 2'd3);
    send(8'h18, 2'd0, 2'd0);
    in_valid = 1'b0;
    chk("rr_pre_valid", out_valid, 4'b0011);
    out_ack = 4'b0001;
    idle_cycle();
    chk("rr_pre_ptr", rr_ptr, 2'd1);
    chk("rr_pre_valid2", out_valid, 4'b0010);

    // Full R1 at pointer stalls everything although others are empty.
    out_ack = 4'b0000;
    in_data = 8'h30; in_valid = 1'b1;
    #1 chk("rr_stall_ready", in_ready, 1'b0);
    idle_cycle();
    chk("rr_stall_ptr", rr_ptr, 2'd1);
    chk("rr_stall_R1", R1, 8'h15);
    out_ack = 4'b0010;
    send(8'h30, 2'd0, 2'd1);
    out_ack = 4'b0000; in_valid = 1'b0;
    chk("rr_resume_ptr", rr_ptr, 2'd2);

    // Clear, then a spurious ack on empty channels changes nothing.
    out_ack = 4'b1111;
    idle_cycle();
    idle_cycle();
    out_ack = 4'b0000;
    chk("spur_valid", out_valid, 4'b0000);
    chk("spur_R0", R0, 8'h18);
    chk("spur_R1", R1, 8'h30);
    chk("spur_R2", R2, 8'h16);
    chk("spur_R3", R3, 8'h17);
    chk("spur_ptr", rr_ptr, 2'd2);

    // Explicit word leaves pointer alone; rr resumes from held value.
    rr_mode = 1'b0;
    send(8'h40, 2'd3, 2'd3);
    chk("toggle_ptr_hold", rr_ptr, 2'd2);
    rr_mode = 1'b1;
    send(8'h41, 2'd0, 2'd2);
    in_valid = 1'b0;
    chk("toggle_ptr_resume", rr_ptr, 2'd3);

    // Reset coincides with accept+take on ch3; reset must win.
    out_ack = 4'b1000;
    in_data = 8'h99; in_valid = 1'b1; rst = 1'b1;
    idle_cycle();
    rst = 1'b0; in_valid = 1'b0; out_ack = 4'b0000;
    chk("rstmid_R3", R3, 8'h00);
    chk("rstmid_R2", R2, 8'h00);
    chk("rstmid_valid", out_valid, 4'b0000);
    chk("rstmid_ptr", rr_ptr, 2'd0);
    #1 chk("rstmid_ready", in_ready, 1'b1);

    idle_cycle();
    idle_cycle();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
